// File: rtl/operand_loader_if.sv
// Operand loader bus: serial byte input stream and 9x8 multiplicand/multiplier output pair.
// With OPERAND_LOADER_ZERO_SKIP_EN defined the bus also carries skip_cnt.
interface operand_loader_if;
    logic [7:0]  in_data;
    logic        in_is_w;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] multiplicand;
    logic [71:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic        w_ok;
`ifdef OPERAND_LOADER_ZERO_SKIP_EN
    logic [7:0]  skip_cnt;

    modport slave (
        input  in_data, in_is_w, in_valid, out_ready,
        output in_ready, multiplicand, multiplier, out_valid, w_ok, skip_cnt
    );
    modport master (
        output in_data, in_is_w, in_valid, out_ready,
        input  in_ready, multiplicand, multiplier, out_valid, w_ok, skip_cnt
    );
`else
    modport slave (
        input  in_data, in_is_w, in_valid, out_ready,
        output in_ready, multiplicand, multiplier, out_valid, w_ok
    );
    modport master (
        output in_data, in_is_w, in_valid, out_ready,
        input  in_ready, multiplicand, multiplier, out_valid, w_ok
    );
`endif
endinterface

// File: rtl/operand_loader.sv
// Collects serial weight/activation bytes into 9-element operand buses for the multiplier array.
// Optional OPERAND_LOADER_ZERO_SKIP_EN drops all-zero activation windows and counts them.
module operand_loader (
    input  logic         clk,
    input  logic         rst_n,
    operand_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WLOAD, RUN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      w_cnt, a_cnt;
    logic [0:8][7:0] w_sh, a_sh, w_nxt, a_nxt;
    logic [71:0]     mult_q, mcand_q;
    logic            ov_q;
    logic            in_ready, w_rdy, a_rdy;
    logic            w_acc, a_acc, w_last, a_last, present;

    always_comb begin
        state_nxt = state;
        // Weights wait for an empty fill buffer and an empty output so a window never mixes sets.
        w_rdy     = (a_cnt == 4'd0) && !ov_q;
        a_rdy     = (state == RUN) && !((a_cnt == 4'd8) && ov_q && !bus.out_ready);
        in_ready  = rst_n && (bus.in_is_w ? w_rdy : a_rdy);
        w_acc     = bus.in_valid && in_ready && bus.in_is_w;
        a_acc     = bus.in_valid && in_ready && !bus.in_is_w;
        w_last    = w_acc && (w_cnt == 4'd8);
        a_last    = a_acc && (a_cnt == 4'd8);
        w_nxt     = w_sh;
        w_nxt[w_cnt] = bus.in_data;
        a_nxt     = a_sh;
        a_nxt[a_cnt] = bus.in_data;
`ifdef OPERAND_LOADER_ZERO_SKIP_EN
        present   = a_last && (a_nxt != '0);
`else
        present   = a_last;
`endif
        case (state)
            IDLE:    if (w_acc)  state_nxt = WLOAD;
            WLOAD:   if (w_last) state_nxt = RUN;
            RUN:     if (w_acc)  state_nxt = WLOAD;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt   <= '0;
            a_cnt   <= '0;
            w_sh    <= '0;
            a_sh    <= '0;
            mult_q  <= '0;
            mcand_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            if (w_acc) begin
                w_sh  <= w_nxt;
                w_cnt <= w_last ? 4'd0 : w_cnt + 4'd1;
            end
            // The shadow is published only once the set is complete.
            if (w_last) mult_q <= w_nxt;
            if (a_acc) begin
                a_sh  <= a_nxt;
                a_cnt <= a_last ? 4'd0 : a_cnt + 4'd1;
            end
            if (present) begin
                mcand_q <= a_nxt;
                ov_q    <= 1'b1;
            end else if (ov_q && bus.out_ready) begin
                ov_q    <= 1'b0;
            end
        end
    end

`ifdef OPERAND_LOADER_ZERO_SKIP_EN
    logic [7:0] skip_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        skip_q <= '0;
        else if (a_last && (a_nxt == '0) && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
    end

    assign bus.skip_cnt = skip_q;
`endif

    assign bus.in_ready     = in_ready;
    assign bus.multiplier   = mult_q;
    assign bus.multiplicand = mcand_q;
    assign bus.out_valid    = ov_q;
    assign bus.w_ok         = (state == RUN);
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: byte-queue reference model checked every cycle plus literal checks.
module tb_operand_loader;
    logic clk, rst_n;
    operand_loader_if bus ();

    operand_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: byte queues for the sets in progress, registers for what is presented.
    logic [7:0]  wq[$];
    logic [7:0]  aq[$];
    logic [71:0] drained[$];
    bit          m_loaded = 0;
    logic [71:0] m_mult = '0, m_mcand = '0;
    bit          m_ov = 0;
    int          m_skip = 0;
    bit          last_ov = 0;
    logic [71:0] last_mc = '0;
    bit          acc;
    logic [71:0] win;

    function automatic logic [71:0] pack9(input logic [7:0] q[$]);
        logic [71:0] v = '0;
        foreach (q[i]) v = {v[63:0], q[i]};
        return v;
    endfunction

    function automatic bit exp_ready();
        if (!rst_n) return 1'b0;
        if (bus.in_is_w) return (aq.size() == 0) && !m_ov;
        return m_loaded && !((aq.size() == 8) && m_ov && !bus.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq.delete(); aq.delete();
            m_loaded = 0; m_mult = '0; m_mcand = '0; m_ov = 0; m_skip = 0;
            last_ov = 0;
        end else begin
            acc = bus.in_valid && exp_ready();
            if (last_ov && bus.out_ready) drained.push_back(last_mc);
            if (m_ov && bus.out_ready) m_ov = 0;
            if (acc && bus.in_is_w) begin
                m_loaded = 0;
                wq.push_back(bus.in_data);
                if (wq.size() == 9) begin
                    m_mult = pack9(wq);
                    wq.delete();
                    m_loaded = 1;
                end
            end
            if (acc && !bus.in_is_w) begin
                aq.push_back(bus.in_data);
                if (aq.size() == 9) begin
                    win = pack9(aq);
                    aq.delete();
`ifdef OPERAND_LOADER_ZERO_SKIP_EN
                    if (win == '0) begin
                        if (m_skip < 255) m_skip++;
                    end else begin
                        m_mcand = win;
                        m_ov    = 1;
                    end
`else
                    m_mcand = win;
                    m_ov    = 1;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {71'd0, bus.in_ready}, {71'd0, exp_ready()});
        chk("out_valid", {71'd0, bus.out_valid}, {71'd0, m_ov});
        chk("w_ok", {71'd0, bus.w_ok}, {71'd0, m_loaded});
        chk("multiplier", bus.multiplier, m_mult);
        chk("multiplicand", bus.multiplicand, m_mcand);
`ifdef OPERAND_LOADER_ZERO_SKIP_EN
        chk("skip_cnt", {64'd0, bus.skip_cnt}, 72'(m_skip));
`endif
        last_ov = bus.out_valid;
        last_mc = bus.multiplicand;
    end

    // Presents one byte and returns #1 after the edge on which it is accepted.
    task automatic send(input logic [7:0] d, input bit w);
        bit done = 0;
        bus.in_data = d; bus.in_is_w = w; bus.in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) chk("send_timeout", 72'd0, 72'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ov"},    {71'd0, bus.out_valid}, 72'd0);
        chk({nm, "_wok"},   {71'd0, bus.w_ok},      72'd0);
        chk({nm, "_rdy"},   {71'd0, bus.in_ready},  72'd0);
        chk({nm, "_mult"},  bus.multiplier,          72'd0);
        chk({nm, "_mcand"}, bus.multiplicand,        72'd0);
    endtask

    localparam logic [71:0] WIN_A = 72'h101112131415161718;
    localparam logic [71:0] WIN_B = 72'h202122232425262728;

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_is_w = 1'b0; bus.out_ready = 1'b0;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Activation byte while IDLE is refused.
        @(posedge clk); #1;
        bus.in_data = 8'h55; bus.in_is_w = 1'b0; bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_act_rdy", {71'd0, bus.in_ready}, 72'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("idle_act_ov", {71'd0, bus.out_valid}, 72'd0);

        // Weight set 01..09.
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b1);
            if (i == 8) chk("w_ok_partial", {71'd0, bus.w_ok}, 72'd0);
        end
        chk("w_ok_loaded", {71'd0, bus.w_ok}, 72'd1);
        chk("mult_set1", bus.multiplier, 72'h010203040506070809);

        // First window, with a refused weight byte after the third activation.
        bus.out_ready = 1'b1;
        send(8'h80, 0); send(8'h7F, 0); send(8'hFF, 0);
        bus.in_data = 8'hAA; bus.in_is_w = 1'b1; bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("fill3_w_rdy", {71'd0, bus.in_ready}, 72'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0);
        chk("win1_ov", {71'd0, bus.out_valid}, 72'd1);
        chk("win1_mcand", bus.multiplicand, 72'h807FFF001122334455);
        @(posedge clk); #1;
        chk("win1_drop", {71'd0, bus.out_valid}, 72'd0);
        chk("win1_mult_kept", bus.multiplier, 72'h010203040506070809);

        // Backpressure: two windows queued behind a stalled output.
        @(posedge clk); #1;
        drained.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 0);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 0);
        bus.in_data = 8'h28; bus.in_is_w = 1'b0; bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_rdy", {71'd0, bus.in_ready}, 72'd0);
            chk("bp_hold_ov", {71'd0, bus.out_valid}, 72'd1);
            chk("bp_hold_a", bus.multiplicand, WIN_A);
        end
        #1 bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_b2b_ov", {71'd0, bus.out_valid}, 72'd1);
        chk("bp_b2b_b", bus.multiplicand, WIN_B);
        @(posedge clk); #1;
        chk("bp_drop", {71'd0, bus.out_valid}, 72'd0);
        chk("bp_count", 72'(drained.size()), 72'd2);
        if (drained.size() == 2) begin
            chk("bp_order0", drained[0], WIN_A);
            chk("bp_order1", drained[1], WIN_B);
        end

        // Asynchronous reset mid-window.
        for (int i = 1; i <= 5; i++) send(8'(i), 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) send(8'hF0 + 8'(i), 1'b1);
        chk("rst_mult", bus.multiplier, 72'hF1F2F3F4F5F6F7F8F9);
        for (int i = 9; i >= 1; i--) send(8'(i), 0);
        chk("rst_ov", {71'd0, bus.out_valid}, 72'd1);
        chk("rst_mcand", bus.multiplicand, 72'h090807060504030201);
        @(posedge clk); #1;

`ifdef OPERAND_LOADER_ZERO_SKIP_EN
        for (int i = 0; i < 9; i++) send(8'h00, 0);
        chk("zs_ov", {71'd0, bus.out_valid}, 72'd0);
        chk("zs_cnt", {64'd0, bus.skip_cnt}, 72'd1);
        for (int i = 1; i <= 9; i++) send(8'(i), 0);
        chk("zs_next_ov", {71'd0, bus.out_valid}, 72'd1);
        chk("zs_next_mcand", bus.multiplicand, 72'h010203040506070809);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
